// File: rtl/posit_normaliser.sv
// Normalise-and-encode stage closing the posit add path: shifts the mantissa until the hidden bit
// is in bit 7, then packs an N-bit posit. Optional round-to-nearest-even via POSIT_NORM_ROUND_EN.
package common;
  typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;
endpackage

module posit_normaliser
  import common::*;
#(
  parameter int N  = 8,
  parameter int EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_negate,
  input  logic [7:0]   in_regime,
  input  logic [7:0]   in_exponent,
  input  logic [7:0]   in_mantissa,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_posit,
  output logic         busy
);

  localparam int SW = 2*N + EN + 7;
  localparam logic signed [11:0] KMAX = 12'(N-2);
  localparam logic signed [11:0] KMIN = -KMAX;

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  state_t             state_q;
  sign_t              neg_q;
  logic [7:0]         mant_q;
  logic signed [11:0] scale_q;
  logic [N-1:0]       posit_q;
  logic               in_ready_q, out_valid_q, busy_q;

  logic signed [11:0] in_scale;
  logic signed [11:0] ko;
  logic [EN-1:0]      eo;
  logic [4:0]         rlen;
  logic [N-1:0]       reg_w;
  logic [SW-1:0]      str;
  logic [N-2:0]       mag, mag_r;
  logic               guard, sticky;
  logic [N-1:0]       posit_d;

  assign in_scale = ($signed({{4{in_regime[7]}}, in_regime}) <<< EN)
                  + $signed({{4{in_exponent[7]}}, in_exponent});

  assign ko = scale_q >>> EN;
  assign eo = scale_q[EN-1:0];

  always_comb begin
    rlen  = '0;
    reg_w = '0;
    if (!ko[11]) begin
      rlen  = ko[4:0] + 5'd2;
      reg_w = (~({N{1'b1}} << (ko[4:0] + 5'd1))) << 1;
    end else begin
      // -ko + 1 == ~ko + 2; only the low bits matter once ko is in range
      rlen  = ~ko[4:0] + 5'd2;
      reg_w = N'(1);
    end
    str    = {reg_w, eo, mant_q[6:0], {N{1'b0}}} << (5'(N) - rlen);
    mag    = str[SW-1 -: N-1];
    guard  = str[SW-N];
    sticky = |str[SW-N-1:0];

`ifdef POSIT_NORM_ROUND_EN
    if (guard & (sticky | mag[0])) begin
      mag_r = (&mag) ? mag : mag + 1'b1;
    end else begin
      mag_r = mag;
    end
`else
    mag_r = mag;
`endif
    if (mag_r == '0) mag_r = (N-1)'(1);

    if (ko >= KMAX) mag_r = {(N-1){1'b1}};
    else if (ko < KMIN) mag_r = (N-1)'(1);

    if (mant_q == 8'h00) posit_d = '0;
    else if (neg_q == NEG) posit_d = ({1'b0, mag_r} ^ {N{1'b1}}) + N'(1);
    else posit_d = {1'b0, mag_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      neg_q       <= POS;
      mant_q      <= '0;
      scale_q     <= '0;
      posit_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          neg_q      <= in_negate ? NEG : POS;
          mant_q     <= in_mantissa;
          scale_q    <= in_scale;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= NORM;
        end
        NORM: begin
          if (mant_q == 8'h00 || mant_q[7]) begin
            state_q <= PACK;
          end else begin
            mant_q  <= mant_q << 1;
            scale_q <= scale_q - 12'sd1;
          end
        end
        PACK: begin
          posit_q     <= posit_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_posit = posit_q;

endmodule

// File: tb/tb_posit_normaliser.sv
// Bench for posit_normaliser at N=8, EN=1: vector table with a result/latency scoreboard,
// plus backpressure and mid-normalise reset sequences.
module tb_posit_normaliser;
  localparam int N  = 8;
  localparam int EN = 1;

`ifdef POSIT_NORM_ROUND_EN
  localparam logic [7:0] EXP_FF  = 8'h50;
  localparam logic [7:0] EXP_K5C = 8'h7F;
`else
  localparam logic [7:0] EXP_FF  = 8'h4F;
  localparam logic [7:0] EXP_K5C = 8'h7E;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_negate;
  logic [7:0]   in_regime, in_exponent, in_mantissa;
  logic         out_valid, out_ready, busy;
  logic [N-1:0] out_posit;

  always #5 clk = ~clk;

  posit_normaliser #(.N(N), .EN(EN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_negate(in_negate),
    .in_regime(in_regime), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit), .busy(busy)
  );

  typedef struct {
    logic [7:0] k;
    logic [7:0] e;
    logic [7:0] m;
    logic       neg;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[16];
  logic [7:0] sb_posit[$];
  int         sb_lat[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lzc(input logic [7:0] m);
    int n = 0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) break;
      n++;
    end
    return (m == 8'h00) ? 0 : n;
  endfunction

  // Drive one operand, wait for its result, hold off out_ready for `hold` cycles, then hand off.
  task automatic run_op(input logic [7:0] k, input logic [7:0] e, input logic [7:0] m,
                        input logic neg, input logic [7:0] exp, input int hold);
    int         cyc;
    logic [7:0] want;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_regime = k; in_exponent = e; in_mantissa = m; in_negate = neg;
    sb_posit.push_back(exp);
    sb_lat.push_back(2 + lzc(m));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      check("busy_inflight", 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      check("timeout_out_valid", 32'(out_valid), 32'd1);
      void'(sb_posit.pop_front());
      void'(sb_lat.pop_front());
      return;
    end
    want = sb_posit.pop_front();
    check("latency", 32'(cyc), 32'(sb_lat.pop_front()));
    check("posit", 32'(out_posit), 32'(want));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_mantissa = 8'h00; in_regime = 8'h03;
      @(negedge clk);
      check("hold_posit", 32'(out_posit), 32'(want));
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_handoff", 32'(in_ready), 32'd1);
    check("out_valid_after_handoff", 32'(out_valid), 32'd0);
    check("busy_after_handoff", 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    tbl[0]  = '{8'h00, 8'h00, 8'h80, 1'b0, 8'h40};   // unity
    tbl[1]  = '{8'h00, 8'h00, 8'h20, 1'b0, 8'h20};   // two shifts, ko=-1
    tbl[2]  = '{8'h00, 8'h00, 8'h20, 1'b1, 8'hE0};
    tbl[3]  = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h00};   // zero ignores sign
    tbl[4]  = '{8'h0A, 8'h00, 8'h80, 1'b0, 8'h7F};   // maxpos
    tbl[5]  = '{8'hF6, 8'h00, 8'h80, 1'b0, 8'h01};   // minpos
    tbl[6]  = '{8'h0A, 8'h00, 8'h80, 1'b1, 8'h81};
    tbl[7]  = '{8'h00, 8'h00, 8'hFF, 1'b0, EXP_FF};
    tbl[8]  = '{8'h01, 8'h00, 8'h80, 1'b0, 8'h60};
    tbl[9]  = '{8'h00, 8'h02, 8'h80, 1'b0, 8'h60};   // exponent outside field range
    tbl[10] = '{8'hFF, 8'h00, 8'hC0, 1'b0, 8'h28};
    tbl[11] = '{8'h00, 8'h00, 8'h01, 1'b0, 8'h06};   // seven shifts
    tbl[12] = '{8'h00, 8'h00, 8'h40, 1'b1, 8'hD0};
    tbl[13] = '{8'hFA, 8'h00, 8'h80, 1'b1, 8'hFF};   // ko=-(N-2), last in-range regime
    tbl[14] = '{8'h06, 8'h00, 8'h80, 1'b0, 8'h7F};   // ko=N-2 saturates
    tbl[15] = '{8'h05, 8'h01, 8'hC0, 1'b0, EXP_K5C};

    rst_n = 1'b0; in_valid = 1'b0; in_negate = 1'b0; out_ready = 1'b0;
    in_regime = '0; in_exponent = '0; in_mantissa = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_posit", 32'(out_posit), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op(tbl[i].k, tbl[i].e, tbl[i].m, tbl[i].neg, tbl[i].exp, 0);

    // Backpressure with stray in_valid while the result is held
    run_op(8'h00, 8'h00, 8'h80, 1'b1, 8'hC0, 5);

    // Reset while normalising m=0x01: operand must vanish
    @(negedge clk);
    in_valid = 1'b1; in_regime = 8'h00; in_exponent = 8'h00; in_mantissa = 8'h01; in_negate = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    run_op(8'h00, 8'h00, 8'h80, 1'b0, 8'h40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_normaliser.md
# posit_normaliser

Iterative normalise-and-encode stage that closes the posit add path. It accepts the interim sign, regime, exponent and unnormalised 8-bit mantissa produced by the mantissa adder and shifts the mantissa left until the hidden bit is in bit 7. It then re-splits the scale into regime and exponent, rounds, and packs an N-bit posit, two's-complementing the result when negation is requested. Valid/ready on both sides; one operation in flight.

## Interface
- `N`, 8, output posit width in bits (6..16)
- `EN`, 1, exponent field width (es); must match the adder's `EN`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  interim operand valid
- `in_ready`  out  1  block can accept an operand
- `in_negate`  in  1  final result must be negated (the adder's `negate_result`)
- `in_regime`  in  8  signed interim regime k
- `in_exponent`  in  8  signed interim exponent e; may lie outside [0, 2^EN-1]
- `in_mantissa`  in  8  unsigned mantissa m; the value is m/128
- `out_valid`  out  1  `out_posit` valid
- `out_ready`  in  1  downstream accepts the result
- `out_posit`  out  N  encoded posit
- `busy`  out  1  high in any state other than IDLE

## Operation
- Value represented: (-1)^neg × 2^(k·2^EN + e) × m/128.
- Capture: on the in_valid&in_ready edge, register neg and m, plus scale s = (k<<<EN)+e as a signed 12-bit value.
- FSM states:
  - **IDLE**: `in_ready`=1. Moves to NORM on accept.
  - **NORM**: if m==0 or m[7]==1, go to PACK. Otherwise m<<=1 and s-=1, then stay in NORM. At most 7 shift cycles.
  - **PACK**: one cycle. Computes the encoding, registers `out_posit`, goes to DONE.
  - **DONE**: `out_valid`=1. Moves to IDLE on out_ready.
- Encoding in PACK:
  - ko = s>>>EN (arithmetic shift) and eo = s[EN-1:0].
  - Regime field: ko≥0 gives ko+1 ones then a zero; ko<0 gives -ko zeros then a one.
  - Magnitude bit string = regime ‖ eo ‖ m[6:0]. Its top N-1 bits form the magnitude.
  - guard = the next bit; sticky = OR of all remaining bits.
- Special cases:
  - m==0 gives `out_posit`=0 regardless of neg.
  - ko ≥ N-2 saturates to maxpos, {1'b0,{N-1{1'b1}}}.
  - ko < -(N-2) saturates to minpos, 1.
  - Rounding (if enabled) never pushes the magnitude past maxpos and never rounds it down to 0.
- Negation: if neg and the magnitude is nonzero, `out_posit` = two's complement of {1'b0, magnitude}.
- Uses the `sign_t` POS/NEG encoding from `common` for any internal sign handling.

## Timing
- Reset (async assert, sync deassert by the surrounding reset tree):
  - state=IDLE; `in_ready`=1; `out_valid`=0; `busy`=0; `out_posit`=0.
- Reset mid-operation discards the in-flight operand. No output is produced for it.
- Latency from the accept edge to `out_valid` rising is 2+L cycles:
  - L = leading zeros of m (0..7).
  - m==0 gives latency 2.
- `out_posit` is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready`=0 in NORM, PACK and DONE.
- Handing off from DONE to IDLE takes one cycle. The next accept is possible one cycle after the output handshake, so there are no same-cycle in/out handshakes.
- `in_*` is ignored when `in_ready`=0.

## Configuration
- `POSIT_NORM_ROUND_EN` defined: round to nearest, ties to even. Increment the magnitude when guard & (sticky | lsb), then clamp to maxpos.
- Undefined: truncate (guard and sticky are ignored). Saturation and zero rules are unchanged.

## Test plan
Default N=8, EN=1.
- **Unity:** k=0, e=0, m=0x80, neg=0 → 0x40; out_valid 2 cycles after accept.
- **Normalise and negate:**
  - k=0, e=0, m=0x20 → s=-2, ko=-1 → 0x20 after 4 cycles.
  - Same operand with neg=1 → 0xE0.
- **Zero and saturation:**
  - m=0x00, neg=1 → 0x00, latency 2.
  - k=10, m=0x80 → 0x7F.
  - k=-10, m=0x80 → 0x01.
  - k=10, m=0x80, neg=1 → 0x81.
- **Rounding:** k=0, e=0, m=0xFF:
  - with `POSIT_NORM_ROUND_EN` → 0x50;
  - without → 0x4F.
- **Backpressure:** hold out_ready=0 for 5 cycles → out_posit constant, in_ready=0, busy=1. Assert out_ready → next cycle in_ready=1.
- **Reset mid-NORM:** m=0x01, drop rst_n on cycle 3 → out_valid never asserts, in_ready=1 immediately. A following k=0, e=0, m=0x80 operand → 0x40.
